// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus between decode and the immediate-extension stage.
// master drives requests and accepts results; slave is the stage itself.
interface imm_extend_pipe_if #(
  parameter int IMM_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_WIDTH-1:0]  in_imm;
  logic [2:0]            in_op;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_illegal;

  modport master (
    output in_valid, in_imm, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_imm, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: zero/sign extend, upper shift and
// branch-offset modes, behind a valid/ready handshake with a 2-entry skid
// buffer so that in_ready comes straight from a flop.
module imm_extend_pipe #(
  parameter int IMM_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BR_SHIFT   = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_extend_pipe_if.slave    bus
);

  localparam int PAD_W = DATA_WIDTH - IMM_WIDTH;

  // Returns {illegal, operand}; undefined opcodes fall back to zero-extend.
  function automatic logic [DATA_WIDTH:0] extend(input logic [IMM_WIDTH-1:0] imm,
                                                 input logic [2:0]           op);
    logic        [DATA_WIDTH-1:0] zext;
    logic signed [DATA_WIDTH-1:0] sext;
    logic        [DATA_WIDTH-1:0] res;
    logic                         ill;
    zext = {{PAD_W{1'b0}}, imm};
    sext = {{PAD_W{imm[IMM_WIDTH-1]}}, imm};
    ill  = 1'b0;
    case (op)
      3'd0:    res = zext;
      3'd1:    res = sext;
      3'd2:    res = zext << PAD_W;
      3'd3:    res = sext <<< BR_SHIFT;
      default: begin
        res = zext;
        ill = 1'b1;
      end
    endcase
    return {ill, res};
  endfunction

  // ---- stage p0: combinational extension of the incoming immediate ----
  logic [DATA_WIDTH-1:0] ext_data_p0;
  logic                  ext_ill_p0;

  assign {ext_ill_p0, ext_data_p0} = extend(bus.in_imm, bus.in_op);

  // ---- stage p1: output register (OUT) and skid register (SKID) ----
  logic                  vld_p1;
  logic                  skid_vld_p1;
  logic                  rdy_p1;
  logic [DATA_WIDTH-1:0] out_data_p1;
  logic [TAG_WIDTH-1:0]  out_tag_p1;
  logic                  out_ill_p1;
  logic [DATA_WIDTH-1:0] skid_data_p1;
  logic [TAG_WIDTH-1:0]  skid_tag_p1;
  logic                  skid_ill_p1;

  logic in_xfer;
  logic out_free;

  assign in_xfer  = bus.in_valid & rdy_p1;
  assign out_free = ~vld_p1 | bus.out_ready;

  // Handshake control: OUT/SKID occupancy and the registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
    end else if (out_free) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
        rdy_p1      <= 1'b1;
      end else begin
        vld_p1      <= in_xfer;
      end
    end else if (in_xfer) begin
      skid_vld_p1 <= 1'b1;
      rdy_p1      <= 1'b0;
    end
  end

  // OUT payload: refilled from SKID first to keep FIFO order, else from input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_p1 <= '0;
      out_tag_p1  <= '0;
      out_ill_p1  <= 1'b0;
    end else if (!flush && out_free) begin
      if (skid_vld_p1) begin
        out_data_p1 <= skid_data_p1;
        out_tag_p1  <= skid_tag_p1;
        out_ill_p1  <= skid_ill_p1;
      end else if (in_xfer) begin
        out_data_p1 <= ext_data_p0;
        out_tag_p1  <= bus.in_tag;
        out_ill_p1  <= ext_ill_p0;
      end
    end
  end

  // SKID payload: catches the one entry accepted while OUT is stalled.
  always_ff @(posedge clk) begin
    if (!flush && !out_free && in_xfer) begin
      skid_data_p1 <= ext_data_p0;
      skid_tag_p1  <= bus.in_tag;
      skid_ill_p1  <= ext_ill_p0;
    end
  end

  assign bus.in_ready    = rdy_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_data    = out_data_p1;
  assign bus.out_tag     = out_tag_p1;
  assign bus.out_illegal = out_ill_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: scoreboard queue filled by the driver, drained
// by a monitor; directed mode/back-pressure/flush/reset cases, a random run,
// and a second instance with a wider operand and narrower immediate.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IMM_WIDTH(16), .DATA_WIDTH(32), .TAG_WIDTH(5)) ba ();
  imm_extend_pipe_if #(.IMM_WIDTH(12), .DATA_WIDTH(64), .TAG_WIDTH(5)) bb ();

  imm_extend_pipe #(.IMM_WIDTH(16), .DATA_WIDTH(32), .BR_SHIFT(2), .TAG_WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ba));

  imm_extend_pipe #(.IMM_WIDTH(12), .DATA_WIDTH(64), .BR_SHIFT(1), .TAG_WIDTH(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(bb));

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: operand value from plain integer arithmetic on the immediate.
  function automatic logic [64:0] ref_ext(input int unsigned imm, input int op,
                                          input int iw, input int dw, input int bs);
    longint uv, sv;
    logic [63:0] v;
    logic ill;
    uv  = longint'(imm);
    sv  = ((imm >> (iw - 1)) != 0) ? uv - (longint'(1) << iw) : uv;
    ill = 1'b0;
    case (op)
      0:       v = uv;
      1:       v = sv;
      2:       v = uv * (longint'(1) << (dw - iw));
      3:       v = sv * (longint'(1) << bs);
      default: begin v = uv; ill = 1'b1; end
    endcase
    if (dw < 64) v = v & ((64'd1 << dw) - 64'd1);
    return {ill, v};
  endfunction

  task automatic push_a();
    logic [64:0] r;
    r = ref_ext(int'(ba.in_imm), int'(ba.in_op), 16, 32, 2);
    q.push_back('{data: r[63:0], tag: ba.in_tag, ill: r[64]});
  endtask

  // Present one entry on A (called just after a rising edge) until accepted.
  task automatic send(input logic [15:0] imm, input logic [2:0] op, input logic [4:0] tag);
    bit ok;
    ok = 1'b0;
    ba.in_valid = 1'b1;
    ba.in_imm   = imm;
    ba.in_op    = op;
    ba.in_tag   = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ba.in_ready) begin
        push_a();
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ba.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %0d never accepted", tag);
    end
  endtask

  // Monitor: pops on every output transfer and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_tag;
  logic        hold_ill;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(ba.out_valid), 64'd1);
          chk("stall_data",  64'(ba.out_data),  64'(hold_data));
          chk("stall_tag",   64'(ba.out_tag),   64'(hold_tag));
          chk("stall_ill",   64'(ba.out_illegal), 64'(hold_ill));
        end
        if (ba.out_valid && ba.out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: tag %0h data %0h with nothing pending",
                     ba.out_tag, ba.out_data);
          end else begin
            e = q.pop_front();
            chk("sb_data", 64'(ba.out_data), e.data);
            chk("sb_tag",  64'(ba.out_tag),  64'(e.tag));
            chk("sb_ill",  64'(ba.out_illegal), 64'(e.ill));
          end
        end
        prev_stall = ba.out_valid && !ba.out_ready && !flush;
        hold_data  = ba.out_data;
        hold_tag   = ba.out_tag;
        hold_ill   = ba.out_illegal;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] mode_exp [4];
  logic [63:0] b_exp    [2];
  logic [2:0]  b_op     [2];

  initial begin
    mode_exp[0] = 32'h0000_8001;
    mode_exp[1] = 32'hFFFF_8001;
    mode_exp[2] = 32'h8001_0000;
    mode_exp[3] = 32'hFFFE_0004;
    b_op[0] = 3'd3; b_exp[0] = 64'hFFFF_FFFF_FFFF_F000;
    b_op[1] = 3'd2; b_exp[1] = 64'h8000_0000_0000_0000;

    ba.in_valid = 1'b0; ba.in_imm = '0; ba.in_op = '0; ba.in_tag = '0; ba.out_ready = 1'b0;
    bb.in_valid = 1'b0; bb.in_imm = '0; bb.in_op = '0; bb.in_tag = '0; bb.out_ready = 1'b1;

    // Power-on reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(ba.out_valid), 64'd0);
    chk("rst_in_ready",  64'(ba.in_ready),  64'd1);
    chk("rst_out_data",  64'(ba.out_data),  64'd0);
    chk("rst_out_tag",   64'(ba.out_tag),   64'd0);
    chk("rst_out_ill",   64'(ba.out_illegal), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Modes with out_ready high: result one cycle after acceptance
    ba.out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      send(16'h8001, 3'(op), 5'(op));
      @(negedge clk);
      chk("mode_latency_valid", 64'(ba.out_valid), 64'd1);
      chk("mode_data", 64'(ba.out_data), 64'(mode_exp[op]));
      chk("mode_ill",  64'(ba.out_illegal), 64'd0);
      @(posedge clk);
      #1;
    end

    // Undefined opcode
    send(16'h1234, 3'd5, 5'd9);
    @(negedge clk);
    chk("illegal_data", 64'(ba.out_data), 64'h1234);
    chk("illegal_flag", 64'(ba.out_illegal), 64'd1);
    @(posedge clk);
    #1;

    // Wide instance: IMM 12, DATA 64, branch shift 1
    for (int k = 0; k < 2; k++) begin
      bb.in_valid = 1'b1;
      bb.in_imm   = 12'h800;
      bb.in_op    = b_op[k];
      bb.in_tag   = 5'(k);
      @(negedge clk);
      chk("wide_in_ready", 64'(bb.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bb.in_valid = 1'b0;
      @(negedge clk);
      chk("wide_valid", 64'(bb.out_valid), 64'd1);
      chk("wide_data",  bb.out_data, b_exp[k]);
      chk("wide_model", ref_ext(32'h800, int'(b_op[k]), 12, 64, 1), {1'b0, b_exp[k]});
      @(posedge clk);
      #1;
    end

    // Back-pressure: tags 1,2 fill OUT and SKID, tag 3 must wait
    ba.out_ready = 1'b0;
    send(16'($urandom), 3'($urandom_range(0, 7)), 5'd1);
    send(16'($urandom), 3'($urandom_range(0, 7)), 5'd2);
    ba.in_valid = 1'b1;
    ba.in_imm   = 16'h0F0F;
    ba.in_op    = 3'd1;
    ba.in_tag   = 5'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(ba.in_ready), 64'd0);
      chk("bp_out_tag",  64'(ba.out_tag),  64'd1);
      @(posedge clk);
      #1;
    end
    ba.out_ready = 1'b1;
    send(16'h0F0F, 3'd1, 5'd3);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    chk("bp_ready_back", 64'(ba.in_ready), 64'd1);
    chk("bp_drained",    64'(q.size()),    64'd0);
    @(posedge clk);
    #1;

    // Flush with both entries full and a request in the flush cycle
    ba.out_ready = 1'b0;
    send(16'h1111, 3'd0, 5'd10);
    send(16'h2222, 3'd0, 5'd11);
    ba.in_valid = 1'b1;
    ba.in_imm   = 16'h3333;
    ba.in_op    = 3'd0;
    ba.in_tag   = 5'd12;
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ba.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(ba.out_valid), 64'd0);
    chk("flush_in_ready",  64'(ba.in_ready),  64'd1);
    ba.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_quiet", 64'(ba.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(16'h4444, 3'd1, 5'd13);
    @(posedge clk);
    #1;

    // Asynchronous reset between edges while OUT and SKID hold entries
    ba.out_ready = 1'b0;
    send(16'h5555, 3'd2, 5'd14);
    send(16'h6666, 3'd3, 5'd15);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ba.out_valid), 64'd0);
    chk("arst_out_data",  64'(ba.out_data),  64'd0);
    chk("arst_out_tag",   64'(ba.out_tag),   64'd0);
    chk("arst_in_ready",  64'(ba.in_ready),  64'd1);
    q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    ba.out_ready = 1'b1;
    ba.in_valid  = 1'b1;
    ba.in_imm    = 16'hFFFF;
    ba.in_op     = 3'd3;
    ba.in_tag    = 5'd16;
    chk("arst_first_ready", 64'(ba.in_ready), 64'd1);
    push_a();
    @(posedge clk);
    #1;
    ba.in_valid = 1'b0;
    @(negedge clk);
    chk("arst_first_accept", 64'(ba.out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Random traffic with occasional flush
    repeat (800) begin
      ba.in_valid  = ($urandom_range(0, 9) < 7);
      ba.in_imm    = 16'($urandom);
      ba.in_op     = 3'($urandom_range(0, 7));
      ba.in_tag    = 5'($urandom);
      ba.out_ready = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (ba.in_valid && ba.in_ready && !flush) push_a();
      @(posedge clk);
      #1;
      if (flush) q.delete();
    end
    flush = 1'b0;
    ba.in_valid  = 1'b0;
    ba.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Registered, parametrised immediate-extension stage for the pipelined datapath. It takes a raw immediate field plus an extension opcode and produces a DATA_WIDTH operand. Supported modes are zero-extend, sign-extend, shift-to-upper (LUI-style) and branch offset (sign-extend then shift left). It sits between decode and execute behind a valid/ready handshake, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
IMM_WIDTH, 16, width of the raw immediate field.
DATA_WIDTH, 32, output operand width; must be ≥ IMM_WIDTH + BR_SHIFT.
BR_SHIFT, 2, left-shift amount for branch-offset mode.
TAG_WIDTH, 5, sideband tag (e.g. destination register) carried alongside the data.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input transfer request.
in_ready  out  1  stage can accept input; registered.
in_imm  in  IMM_WIDTH  raw immediate.
in_op  in  3  extension opcode.
in_tag  in  TAG_WIDTH  sideband tag.
out_valid  out  1  output holds a valid result.
out_ready  in  1  downstream accepts the result.
out_data  out  DATA_WIDTH  extended operand.
out_tag  out  TAG_WIDTH  tag matching out_data.
out_illegal  out  1  opcode of this result was undefined.

Behaviour:
- Opcode encoding:
  - 0 = zero-extend: {zeros, imm}.
  - 1 = sign-extend: replicate imm[IMM_WIDTH-1].
  - 2 = shift-to-upper: imm << (DATA_WIDTH-IMM_WIDTH), low bits zero.
  - 3 = branch offset: sign-extend, then << BR_SHIFT.
  - 4..7 = undefined: result is the zero-extend value with illegal=1.
- Extension is computed combinationally on the input; the result, tag and illegal flag are captured together in a single entry.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Storage: an output register (OUT) and a skid register (SKID). in_ready = !skid_valid, driven from a flop.
- Each cycle (no flush), when OUT is free (!out_valid | out_ready):
  - skid_valid → OUT←SKID, skid_valid←0.
  - else input transfer → OUT←new entry, out_valid←1.
  - else out_valid←0.
- Each cycle (no flush), when OUT is stalled (out_valid & !out_ready):
  - Input transfer → SKID←new entry, skid_valid←1; in_ready drops next cycle.
- Latency: 1 cycle from input transfer to out_valid when unstalled. Throughput is 1 per cycle with out_ready held high.
- Ordering is strictly FIFO, and no entry is ever dropped or duplicated except by flush.
- out_data, out_tag and out_illegal hold stable while out_valid & !out_ready.
- Flush (synchronous, dominates everything):
  - Next edge: out_valid←0, skid_valid←0, in_ready←1.
  - Input presented in the flush cycle is discarded.
  - Data registers keep their stale values.
- Reset (async, any time including mid-transfer): out_valid=0, skid_valid=0, in_ready=1, out_data=0, out_tag=0, out_illegal=0. In-flight entries are lost.
- Reset deasserting: first acceptance possible on the first rising edge after rst falls.

Test Plan:
- Mode check, DATA_WIDTH=32 with out_ready=1: imm=0x8001 with ops 0/1/2/3 → out_data 0x00008001 / 0xFFFF8001 / 0x80010000 / 0xFFFE0004, each one cycle after acceptance, illegal=0.
- Illegal op: imm=0x1234, op=5 → out_data 0x00001234, out_illegal=1.
- Back-pressure: 3 back-to-back inputs with tags 1,2,3 and out_ready=0 → first lands in OUT, second in SKID, in_ready=0 and third held. Raise out_ready → outputs tags 1,2,3 in order, none lost, in_ready returns to 1.
- Flush with both entries full: assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and no flushed or flush-cycle entry ever appears on the output.
- Async reset mid-stall: assert rst between clock edges with OUT and SKID valid → out_valid=0, out_data=0 and in_ready=1 immediately, without waiting for a clock edge.
- Parameter sweep at IMM_WIDTH=12, DATA_WIDTH=64, BR_SHIFT=1: imm=0x800, op=3 → 0xFFFFFFFFFFFFF000; op=2 → 0x8000000000000000.
